// File: rtl/rdma_tx_pkt_arbiter.sv
// Round-robin arbiter for N_CH send-queue command channels; each grant queues the channel so its data packet follows.
// Latency: command path 1 cycle (registered); data path 0 cycles (combinational steering by queue head).
// Backpressure: a held command or a full grant queue stalls all grants; data beats wait for m_axis_tready and queue head.
module rdma_tx_pkt_arbiter #(
    parameter int N_CH      = 4,
    parameter int CH_BITS   = $clog2(N_CH),
    parameter int META_BITS = 256,
    parameter int DATA_BITS = 512,
    parameter int QDEPTH    = 8,
    parameter int TDEST_VAL = 0
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [N_CH-1:0]               s_meta_valid,
    output logic [N_CH-1:0]               s_meta_ready,
    input  logic [N_CH*META_BITS-1:0]     s_meta_data,
    output logic                          m_meta_valid,
    input  logic                          m_meta_ready,
    output logic [META_BITS-1:0]          m_meta_data,
    output logic [CH_BITS-1:0]            m_meta_id,
    input  logic [N_CH-1:0]               s_axis_tvalid,
    output logic [N_CH-1:0]               s_axis_tready,
    input  logic [N_CH*DATA_BITS-1:0]     s_axis_tdata,
    input  logic [N_CH*DATA_BITS/8-1:0]   s_axis_tkeep,
    input  logic [N_CH-1:0]               s_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [DATA_BITS-1:0]          m_axis_tdata,
    output logic [DATA_BITS/8-1:0]        m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic [CH_BITS-1:0]            m_axis_tid,
    output logic [CH_BITS-1:0]            m_axis_tdest,
    output logic [$clog2(QDEPTH):0]       q_count
);

    localparam int QAW       = $clog2(QDEPTH);
    localparam int KEEP_BITS = DATA_BITS / 8;
    localparam logic [QAW:0] Q_FULL = (QAW+1)'(QDEPTH);

    logic [CH_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic                 meta_vld_q, meta_vld_d;
    logic [META_BITS-1:0] meta_dat_q, meta_dat_d;
    logic [CH_BITS-1:0]   meta_id_q, meta_id_d;
    logic [CH_BITS-1:0]   gq_mem_q [QDEPTH];
    logic [QAW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [QAW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [QAW:0]         cnt_q, cnt_d;

    logic                 grant_ok;
    logic                 grant;
    logic [CH_BITS-1:0]   winner;
    logic [CH_BITS-1:0]   cand;
    int                   cidx;
    logic [CH_BITS-1:0]   head;
    logic                 q_nempty;
    logic                 pop;

    // Round-robin search starting one past the last winner; full test uses the registered count only.
    always_comb begin
        grant_ok = !areset && (!meta_vld_q || m_meta_ready) && (cnt_q < Q_FULL);
        grant    = 1'b0;
        winner   = rr_ptr_q;
        cidx     = 0;
        cand     = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cidx = int'(rr_ptr_q) + k;
            if (cidx >= N_CH) cidx = cidx - N_CH;
            cand = CH_BITS'(cidx);
            if (grant_ok && !grant && s_meta_valid[cand]) begin
                grant  = 1'b1;
                winner = cand;
            end
        end
    end

    // One-hot ready to the winner, and the next command register / pointer contents.
    always_comb begin
        s_meta_ready = '0;
        meta_vld_d   = meta_vld_q;
        meta_dat_d   = meta_dat_q;
        meta_id_d    = meta_id_q;
        rr_ptr_d     = rr_ptr_q;
        for (int i = 0; i < N_CH; i++) begin
            if (grant && winner == CH_BITS'(i)) begin
                s_meta_ready[i] = 1'b1;
                meta_dat_d      = s_meta_data[i*META_BITS +: META_BITS];
            end
        end
        if (grant) begin
            meta_vld_d = 1'b1;
            meta_id_d  = winner;
            rr_ptr_d   = winner;
        end else if (m_meta_ready) begin
            meta_vld_d = 1'b0;
        end
    end

    assign head     = gq_mem_q[rd_ptr_q];
    assign q_nempty = (cnt_q != '0);

    // Steer the head channel's stream to the output; every other channel sees tready low so packets never interleave.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (head == CH_BITS'(i)) begin
                m_axis_tvalid    = q_nempty && !areset && s_axis_tvalid[i];
                m_axis_tdata     = s_axis_tdata[i*DATA_BITS +: DATA_BITS];
                m_axis_tkeep     = s_axis_tkeep[i*KEEP_BITS +: KEEP_BITS];
                m_axis_tlast     = s_axis_tlast[i];
                s_axis_tready[i] = q_nempty && !areset && m_axis_tready;
            end
        end
    end

    assign pop = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Grant queue pointer and occupancy updates; push and pop together leave the count unchanged.
    always_comb begin
        wr_ptr_d = grant ? wr_ptr_q + QAW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + QAW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (grant && !pop) cnt_d = cnt_q + (QAW+1)'(1);
        if (!grant && pop) cnt_d = cnt_q - (QAW+1)'(1);
    end

    // Control state; reset drops the queue and any partially sent packet.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rr_ptr_q   <= CH_BITS'(N_CH - 1);
            meta_vld_q <= 1'b0;
            meta_dat_q <= '0;
            meta_id_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            meta_vld_q <= meta_vld_d;
            meta_dat_q <= meta_dat_d;
            meta_id_q  <= meta_id_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Grant queue storage; entries past rd_ptr are never read so they need no reset.
    always_ff @(posedge aclk) begin
        if (grant) gq_mem_q[wr_ptr_q] <= winner;
    end

    assign m_meta_valid = meta_vld_q;
    assign m_meta_data  = meta_dat_q;
    assign m_meta_id    = meta_id_q;
    assign m_axis_tid   = head;
    assign m_axis_tdest = CH_BITS'(TDEST_VAL);
    assign q_count      = cnt_q;

endmodule
